// File: rtl/watch_mode_scheduler_if.sv
// Shared button/display bus between the watch mode scheduler and its sub-blocks.
// The slave side is the scheduler. The master side is the environment: the button
// debouncer, the ms tick, the three mode blocks and the FND driver.
interface watch_mode_scheduler_if;
  logic [3:0]  btn_pedge;
  logic        tick_msec;
  logic        timer_alarm;
  logic [15:0] value_clock;
  logic [15:0] value_swatch;
  logic [15:0] value_timer;
  logic [2:0]  btn_clock;
  logic [2:0]  btn_swatch;
  logic [2:0]  btn_timer;
  logic        alarm_clr;
  logic [1:0]  mode;
  logic [15:0] value;
  logic        blank;

  modport slave (
    input  btn_pedge, tick_msec, timer_alarm, value_clock, value_swatch, value_timer,
    output btn_clock, btn_swatch, btn_timer, alarm_clr, mode, value, blank
  );

  modport master (
    output btn_pedge, tick_msec, timer_alarm, value_clock, value_swatch, value_timer,
    input  btn_clock, btn_swatch, btn_timer, alarm_clr, mode, value, blank
  );
endinterface

// File: rtl/watch_mode_scheduler.sv
// Mode scheduler for the multi-purpose watch. It routes button edges to the active
// mode (clock, stopwatch or cooking timer) and picks that mode's value for the
// display. A rising timer alarm pre-empts every mode and blinks the display until
// the alarm is acknowledged by a button, times out, or the timer drops the alarm.
module watch_mode_scheduler #(
  parameter int BLINK_MS         = 500,
  parameter int ALARM_TIMEOUT_MS = 10000
) (
  input logic                   clk,
  input logic                   reset_n,
  watch_mode_scheduler_if.slave bus
);

  localparam logic [1:0] ST_CLOCK  = 2'd0;
  localparam logic [1:0] ST_SWATCH = 2'd1;
  localparam logic [1:0] ST_TIMER  = 2'd2;
  localparam logic [1:0] ST_ALARM  = 2'd3;

  localparam int BLINK_W   = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int TIMEOUT_W = (ALARM_TIMEOUT_MS > 1) ? $clog2(ALARM_TIMEOUT_MS) : 1;
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_MS - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(ALARM_TIMEOUT_MS - 1);

  logic [1:0]           state;
  logic [1:0]           saved_mode;
  logic                 timer_alarm_d;
  logic                 alarm_armed;
  logic [BLINK_W-1:0]   blink_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 blank_q;
  logic                 alarm_clr_q;
  logic [2:0]           btn_clock_q;
  logic [2:0]           btn_swatch_q;
  logic [2:0]           btn_timer_q;

  logic alarm_rise;
  logic any_btn;
  logic timeout_hit;

  // A rise only counts once a low level has been seen since reset, so an alarm that
  // is still high when reset is released cannot immediately re-enter ALARM.
  assign alarm_rise  = bus.timer_alarm & ~timer_alarm_d & alarm_armed;
  assign any_btn     = |bus.btn_pedge;
  assign timeout_hit = bus.tick_msec && (timeout_cnt == TIMEOUT_LAST);

  // Alarm edge detector history and arming flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_alarm_d <= 1'b0;
      alarm_armed   <= 1'b0;
    end else begin
      timer_alarm_d <= bus.timer_alarm;
      alarm_armed   <= alarm_armed | ~bus.timer_alarm;
    end
  end

  // Mode sequencing, button forwarding and the alarm blink/timeout handling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_CLOCK;
      saved_mode   <= ST_CLOCK;
      blink_cnt    <= '0;
      timeout_cnt  <= '0;
      blank_q      <= 1'b0;
      alarm_clr_q  <= 1'b0;
      btn_clock_q  <= '0;
      btn_swatch_q <= '0;
      btn_timer_q  <= '0;
    end else begin
      alarm_clr_q  <= 1'b0;
      btn_clock_q  <= '0;
      btn_swatch_q <= '0;
      btn_timer_q  <= '0;
      if (state != ST_ALARM) begin
        if (alarm_rise) begin
          saved_mode  <= state;
          state       <= ST_ALARM;
          blink_cnt   <= '0;
          timeout_cnt <= '0;
          blank_q     <= 1'b0;
        end else if (bus.btn_pedge[0]) begin
          case (state)
            ST_CLOCK:  state <= ST_SWATCH;
            ST_SWATCH: state <= ST_TIMER;
            default:   state <= ST_CLOCK;
          endcase
        end else begin
          case (state)
            ST_CLOCK:  btn_clock_q  <= bus.btn_pedge[3:1];
            ST_SWATCH: btn_swatch_q <= bus.btn_pedge[3:1];
            default:   btn_timer_q  <= bus.btn_pedge[3:1];
          endcase
        end
      end else begin
        if (any_btn || timeout_hit) begin
          alarm_clr_q <= 1'b1;
          state       <= saved_mode;
          blank_q     <= 1'b0;
        end else if (!bus.timer_alarm) begin
          state   <= saved_mode;
          blank_q <= 1'b0;
        end else if (bus.tick_msec) begin
          timeout_cnt <= timeout_cnt + 1'b1;
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blank_q   <= ~blank_q;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Display value follows the registered mode; ALARM shows the timer value.
  always_comb begin
    bus.value = bus.value_timer;
    case (state)
      ST_CLOCK:  bus.value = bus.value_clock;
      ST_SWATCH: bus.value = bus.value_swatch;
      default:   bus.value = bus.value_timer;
    endcase
  end

  assign bus.mode       = state;
  assign bus.blank      = blank_q;
  assign bus.alarm_clr  = alarm_clr_q;
  assign bus.btn_clock  = btn_clock_q;
  assign bus.btn_swatch = btn_swatch_q;
  assign bus.btn_timer  = btn_timer_q;

endmodule

// File: tb/tb_watch_mode_scheduler.sv
// Testbench for watch_mode_scheduler: a vector table for mode stepping and button
// routing, hand-written alarm sequences, then random traffic against a reference model.
module tb_watch_mode_scheduler;

  localparam int BLINK   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset_n;

  watch_mode_scheduler_if bus ();

  watch_mode_scheduler #(
    .BLINK_MS        (BLINK),
    .ALARM_TIMEOUT_MS(TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       tick;
    logic       ta;
    int         mode;
    logic [2:0] bc;
    logic [2:0] bs;
    logic [2:0] bt;
    logic       clr;
    logic       blank;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int errors = 0;

  int         m_mode;
  int         m_saved;
  int         m_ticks;
  bit         m_prev_ta;
  logic [2:0] m_btn[3];
  logic       m_clr;

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] exp_value(input int md);
    if (md == 0) return bus.value_clock;
    if (md == 1) return bus.value_swatch;
    return bus.value_timer;
  endfunction

  task automatic check_output(input string tag, input int e_mode, input logic [2:0] e_bc,
                              input logic [2:0] e_bs, input logic [2:0] e_bt,
                              input logic e_clr, input logic e_blank);
    check_val({tag, " mode"}, 32'(bus.mode), e_mode);
    check_val({tag, " value"}, 32'(bus.value), 32'(exp_value(e_mode)));
    check_val({tag, " btn_clock"}, 32'(bus.btn_clock), 32'(e_bc));
    check_val({tag, " btn_swatch"}, 32'(bus.btn_swatch), 32'(e_bs));
    check_val({tag, " btn_timer"}, 32'(bus.btn_timer), 32'(e_bt));
    check_val({tag, " alarm_clr"}, 32'(bus.alarm_clr), 32'(e_clr));
    check_val({tag, " blank"}, 32'(bus.blank), 32'(e_blank));
  endtask

  // Inputs are set 1 time unit after a rising edge, held across the next edge,
  // and outputs are then sampled 1 time unit after that edge.
  task automatic apply_stimulus(input logic [3:0] btn, input logic tick, input logic ta);
    bus.btn_pedge   = btn;
    bus.tick_msec   = tick;
    bus.timer_alarm = ta;
    @(posedge clk);
    #1;
    bus.btn_pedge = 4'b0000;
    bus.tick_msec = 1'b0;
  endtask

  // Reference model: the alarm is tracked as "ticks seen since entry"; blank is the
  // parity of completed blink periods and the timeout fires on the TIMEOUT-th tick.
  task automatic model_reset();
    m_mode    = 0;
    m_saved   = 0;
    m_ticks   = 0;
    m_prev_ta = 1'b1;
    m_clr     = 1'b0;
    for (int i = 0; i < 3; i++) m_btn[i] = 3'b000;
  endtask

  task automatic model_step(input logic [3:0] btn, input logic tick, input logic ta);
    int nt;
    m_clr = 1'b0;
    for (int i = 0; i < 3; i++) m_btn[i] = 3'b000;
    if (m_mode != 3) begin
      if (ta && !m_prev_ta) begin
        m_saved = m_mode;
        m_mode  = 3;
        m_ticks = 0;
      end else if (btn[0]) begin
        m_mode = (m_mode + 1) % 3;
      end else begin
        m_btn[m_mode] = btn[3:1];
      end
    end else begin
      nt = m_ticks + (tick ? 1 : 0);
      if (btn != 4'b0000 || nt == TIMEOUT) begin
        m_clr  = 1'b1;
        m_mode = m_saved;
      end else if (!ta) begin
        m_mode = m_saved;
      end else begin
        m_ticks = nt;
      end
    end
    m_prev_ta = ta;
  endtask

  function automatic logic model_blank();
    if (m_mode != 3) return 1'b0;
    return 1'((m_ticks / BLINK) % 2);
  endfunction

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    logic ta;

    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 1'b0, 1'b0, 2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{4'b0001, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[3]  = '{4'b0001, 1'b0, 1'b0, 1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[4]  = '{4'b0010, 1'b0, 1'b0, 1, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 1'b0, 1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0011, 1'b0, 1'b0, 2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[7]  = '{4'b1100, 1'b0, 1'b0, 2, 3'b000, 3'b000, 3'b110, 1'b0, 1'b0};
    vecs[8]  = '{4'b0001, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[9]  = '{4'b0100, 1'b0, 1'b0, 0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[11] = '{4'b0001, 1'b0, 1'b1, 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 1'b1, 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[13] = '{4'b0100, 1'b0, 1'b1, 0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0};
    vecs[14] = '{4'b0000, 1'b0, 1'b1, 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    vecs[15] = '{4'b0000, 1'b0, 1'b0, 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};

    reset_n          = 1'b0;
    bus.btn_pedge    = 4'b0000;
    bus.tick_msec    = 1'b0;
    bus.timer_alarm  = 1'b0;
    bus.value_clock  = 16'h1234;
    bus.value_swatch = 16'h5678;
    bus.value_timer  = 16'h9abc;

    @(posedge clk);
    #1;
    check_output("reset held", 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    reset_n = 1'b1;
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    check_output("reset released", 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].btn, vecs[i].tick, vecs[i].ta);
      check_output($sformatf("vec%0d", i), vecs[i].mode, vecs[i].bc, vecs[i].bs,
                   vecs[i].bt, vecs[i].clr, vecs[i].blank);
    end

    $display("[TB] alarm blink and button acknowledge from SWATCH");
    apply_stimulus(4'b0001, 1'b0, 1'b0);
    check_output("to swatch", 1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("alarm enter", 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      apply_stimulus(4'b0000, 1'b1, 1'b1);
      check_output($sformatf("blink tick%0d", k), 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'((k / BLINK) % 2));
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      check_output($sformatf("blink idle%0d", k), 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'((k / BLINK) % 2));
    end
    apply_stimulus(4'b1000, 1'b0, 1'b1);
    check_output("ack by button", 1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("ack pulse end", 1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

    $display("[TB] alarm timeout");
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    check_output("alarm low", 1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("alarm re-enter", 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      apply_stimulus(4'b0000, 1'b1, 1'b1);
      if (k < TIMEOUT)
        check_output($sformatf("timeout tick%0d", k), 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'((k / BLINK) % 2));
      else
        check_output("timeout exit", 1, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    end
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("timeout after", 1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

    $display("[TB] alarm dropped by the timer");
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    apply_stimulus(4'b0001, 1'b0, 1'b0);
    check_output("to timer", 2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("fall enter", 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b1, 1'b1);
    check_output("fall tick", 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    check_output("fall exit", 2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);

    $display("[TB] reset during alarm with alarm held high");
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("pre-reset alarm", 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check_output("async reset", 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      check_output($sformatf("no retrigger%0d", k), 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    end
    apply_stimulus(4'b0000, 1'b0, 1'b0);
    check_output("post-reset low", 0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, 1'b1);
    check_output("new rise", 3, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    apply_stimulus(4'b0010, 1'b0, 1'b1);
    check_output("new rise ack", 0, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);

    $display("[TB] random traffic against reference model");
    reset_n         = 1'b0;
    bus.timer_alarm = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    ta = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] btn;
      logic       tick;
      btn  = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) ta = ~ta;
      bus.value_clock  = 16'($urandom);
      bus.value_swatch = 16'($urandom);
      bus.value_timer  = 16'($urandom);
      model_step(btn, tick, ta);
      apply_stimulus(btn, tick, ta);
      check_output($sformatf("rand%0d", c), m_mode, m_btn[0], m_btn[1], m_btn[2], m_clr, model_blank());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
